// File: rtl/dom_sbox4.sv
// dom_sbox4: two-share DOM-protected 4-bit small-scale AES S-box.
// The input is mapped to the tower field GF((2^2)^2). Elements are written
// h*y + l, with y^2 = y + nu and nu = w, where w is the GF(2^2) generator
// (w^2 = w + 1).
// Under this choice, y is itself a root of x^4 + x + 1. The isomorphism
// therefore sends x^i to y^i.
// Inversion: (h*y + l)^-1 = (h*y + (h^l)) * d^-1, where d = nu*h^2 ^ h*l ^ l^2.
// Pipeline: stage 1 (h*l products), stage 2 (h*d^-1 and (h^l)*d^-1), output.
module dom_sbox4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [1:0] Z0,
    input  logic [1:0] Z1,
    input  logic [1:0] Z2,
    input  logic [1:0] Az0,
    input  logic [1:0] Az1,
    input  logic [1:0] Az2,
    input  logic [1:0] Bz0,
    input  logic [1:0] Bz1,
    input  logic [1:0] Bz2,
    output logic [3:0] A_out,
    output logic [3:0] B_out
);

    // GF(2^2) product. Elements are encoded {b1,b0} = b1*w + b0.
    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        gf4_mul = {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
                   (a[1] & b[1]) ^ (a[0] & b[0])};
    endfunction

    // GF(2^2) square. It is linear, and it equals the inverse for nonzero elements.
    function automatic logic [1:0] gf4_sq(input logic [1:0] a);
        gf4_sq = {a[1], a[1] ^ a[0]};
    endfunction

    // Multiply by nu = w.
    function automatic logic [1:0] gf4_mul_nu(input logic [1:0] a);
        gf4_mul_nu = {a[1] ^ a[0], a[1]};
    endfunction

    // Polynomial basis to tower {h,l}. The images of the basis are
    // 1 -> 0001, x -> 0100, x^2 -> 0110, x^3 -> 1110.
    function automatic logic [3:0] to_tower(input logic [3:0] x);
        to_tower = {x[3], x[1] ^ x[2] ^ x[3], x[2] ^ x[3], x[0]};
    endfunction

    // Tower back to polynomial basis, followed by the linear part of the affine map.
    // The affine constant is not added here.
    function automatic logic [3:0] from_tower_lin(input logic [3:0] t);
        logic [3:0] x;
        x = {t[3], t[1] ^ t[3], t[2] ^ t[1], t[0]};
        from_tower_lin = {x[0] ^ x[1] ^ x[3],
                          x[0] ^ x[2] ^ x[3],
                          x[1] ^ x[2] ^ x[3],
                          x[0] ^ x[1] ^ x[2]};
    endfunction

    // Stage 1 registers. Suffix _a is domain A and _b is domain B.
    // The m0 terms hold inner (i) and cross (x) products.
    logic [1:0] h1_a_q, h1_a_d, h1_b_q, h1_b_d;
    logic [1:0] l1_a_q, l1_a_d, l1_b_q, l1_b_d;
    logic [1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [1:0] m0_ia_q, m0_ia_d, m0_xa_q, m0_xa_d;
    logic [1:0] m0_ib_q, m0_ib_d, m0_xb_q, m0_xb_d;
    logic       vld1_q, vld1_d;

    // Stage 2 registers.
    logic [1:0] m1_ia_q, m1_ia_d, m1_xa_q, m1_xa_d;
    logic [1:0] m1_ib_q, m1_ib_d, m1_xb_q, m1_xb_d;
    logic [1:0] m2_ia_q, m2_ia_d, m2_xa_q, m2_xa_d;
    logic [1:0] m2_ib_q, m2_ib_d, m2_xb_q, m2_xb_d;
    logic       vld2_q, vld2_d;

    // Output registers.
    logic [3:0] a_out_q, a_out_d, b_out_q, b_out_d;

    // Stage-2 intermediates: the d shares and the d^-1 shares.
    logic [1:0] d_a, d_b, di_a, di_b;

    // Output-stage intermediates: the recombined tower shares.
    logic [3:0] y_a, y_b;

    // Stage 1: map each share to the tower field, then form the multiplier-0 terms.
    always_comb begin
        logic [3:0] t_a;
        logic [3:0] t_b;
        logic [1:0] r0;
        t_a     = to_tower(A);
        t_b     = to_tower(B);
        r0      = Az0 ^ Bz0;
        h1_a_d  = t_a[3:2];
        l1_a_d  = t_a[1:0];
        h1_b_d  = t_b[3:2];
        l1_b_d  = t_b[1:0];
        s1_a_d  = t_a[3:2] ^ t_a[1:0];
        s1_b_d  = t_b[3:2] ^ t_b[1:0];
        m0_ia_d = gf4_mul(t_a[3:2], t_a[1:0]) ^ r0;
        m0_xa_d = gf4_mul(t_a[3:2], t_b[1:0]) ^ Z0;
        m0_xb_d = gf4_mul(t_b[3:2], t_a[1:0]) ^ Z0;
        m0_ib_d = gf4_mul(t_b[3:2], t_b[1:0]) ^ r0;
        vld1_d  = 1'b1;
    end

    // Stage 2: finish d per domain and square it to get d^-1.
    // Then form the multiplier-1 and multiplier-2 terms.
    always_comb begin
        logic [1:0] r1;
        logic [1:0] r2;
        r1      = Az1 ^ Bz1;
        r2      = Az2 ^ Bz2;
        d_a     = gf4_mul_nu(gf4_sq(h1_a_q)) ^ gf4_sq(l1_a_q) ^ m0_ia_q ^ m0_xa_q;
        d_b     = gf4_mul_nu(gf4_sq(h1_b_q)) ^ gf4_sq(l1_b_q) ^ m0_ib_q ^ m0_xb_q;
        di_a    = gf4_sq(d_a);
        di_b    = gf4_sq(d_b);
        m1_ia_d = gf4_mul(h1_a_q, di_a) ^ r1;
        m1_xa_d = gf4_mul(h1_a_q, di_b) ^ Z1;
        m1_xb_d = gf4_mul(h1_b_q, di_a) ^ Z1;
        m1_ib_d = gf4_mul(h1_b_q, di_b) ^ r1;
        m2_ia_d = gf4_mul(s1_a_q, di_a) ^ r2;
        m2_xa_d = gf4_mul(s1_a_q, di_b) ^ Z2;
        m2_xb_d = gf4_mul(s1_b_q, di_a) ^ Z2;
        m2_ib_d = gf4_mul(s1_b_q, di_b) ^ r2;
        vld2_d  = vld1_q;
    end

    // Output stage: recombine each domain, apply the inverse map and the affine
    // map, and add the constant to share A. Outputs are held at zero until
    // real data reaches this stage after reset.
    always_comb begin
        y_a     = {m1_ia_q ^ m1_xa_q, m2_ia_q ^ m2_xa_q};
        y_b     = {m1_ib_q ^ m1_xb_q, m2_ib_q ^ m2_xb_q};
        a_out_d = 4'h0;
        b_out_d = 4'h0;
        if (vld2_q) begin
            a_out_d = from_tower_lin(y_a) ^ 4'h6;
            b_out_d = from_tower_lin(y_b);
        end
    end

    // Pipeline registers. A synchronous reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            h1_a_q  <= '0; h1_b_q  <= '0; l1_a_q  <= '0; l1_b_q  <= '0;
            s1_a_q  <= '0; s1_b_q  <= '0;
            m0_ia_q <= '0; m0_xa_q <= '0; m0_ib_q <= '0; m0_xb_q <= '0;
            m1_ia_q <= '0; m1_xa_q <= '0; m1_ib_q <= '0; m1_xb_q <= '0;
            m2_ia_q <= '0; m2_xa_q <= '0; m2_ib_q <= '0; m2_xb_q <= '0;
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
            a_out_q <= '0;
            b_out_q <= '0;
        end else begin
            h1_a_q  <= h1_a_d;  h1_b_q  <= h1_b_d;
            l1_a_q  <= l1_a_d;  l1_b_q  <= l1_b_d;
            s1_a_q  <= s1_a_d;  s1_b_q  <= s1_b_d;
            m0_ia_q <= m0_ia_d; m0_xa_q <= m0_xa_d;
            m0_ib_q <= m0_ib_d; m0_xb_q <= m0_xb_d;
            m1_ia_q <= m1_ia_d; m1_xa_q <= m1_xa_d;
            m1_ib_q <= m1_ib_d; m1_xb_q <= m1_xb_d;
            m2_ia_q <= m2_ia_d; m2_xa_q <= m2_xa_d;
            m2_ib_q <= m2_ib_d; m2_xb_q <= m2_xb_d;
            vld1_q  <= vld1_d;
            vld2_q  <= vld2_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
        end
    end

    assign A_out = a_out_q;
    assign B_out = b_out_q;

endmodule

// File: tb/tb_dom_sbox4.sv
// tb_dom_sbox4: directed and randomized checks of the masked S-box.
// The reference is the S-box table applied to the recombined input.
// Each check appears three cycles after the input is driven.
module tb_dom_sbox4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] A = 4'h0, B = 4'h0;
    logic [1:0] Z0 = 2'h0, Z1 = 2'h0, Z2 = 2'h0;
    logic [1:0] Az0 = 2'h0, Az1 = 2'h0, Az2 = 2'h0;
    logic [1:0] Bz0 = 2'h0, Bz1 = 2'h0, Bz2 = 2'h0;
    logic [3:0] A_out, B_out;

    dom_sbox4 dut (
        .clk(clk), .rst(rst), .A(A), .B(B),
        .Z0(Z0), .Z1(Z1), .Z2(Z2),
        .Az0(Az0), .Az1(Az1), .Az2(Az2),
        .Bz0(Bz0), .Bz1(Bz1), .Bz2(Bz2),
        .A_out(A_out), .B_out(B_out)
    );

    always #5 clk = ~clk;

    localparam int EXP_ZERO = 16;   // queue entry meaning "both shares must be 0"

    logic [3:0] sbox [16];
    int         exp_q [$];
    int         n_vec = 0;
    int         n_bad = 0;
    string      tag = "";

    // Compare the current outputs against one expected entry.
    task automatic check_entry(input int e);
        logic [3:0] ev;
        ev = 4'(e);
        n_vec++;
        if (e == EXP_ZERO) begin
            assert ({A_out, B_out} === 8'h00) else begin
                n_bad++;
                $error("FAIL %s: shares observed %h/%h expected 0/0", tag, A_out, B_out);
            end
        end else begin
            assert ((A_out ^ B_out) === ev) else begin
                n_bad++;
                $error("FAIL %s: xor observed %h expected %h", tag, A_out ^ B_out, ev);
            end
        end
    endtask

    // Apply one input pair, advance one clock, and check the entry due now.
    task automatic step(input logic [3:0] a, input logic [3:0] b, input bit fixed_rnd);
        A = a;
        B = b;
        if (!fixed_rnd) begin
            Z0 = 2'($urandom);  Z1 = 2'($urandom);  Z2 = 2'($urandom);
            Az0 = 2'($urandom); Az1 = 2'($urandom); Az2 = 2'($urandom);
            Bz0 = 2'($urandom); Bz1 = 2'($urandom); Bz2 = 2'($urandom);
        end
        exp_q.push_back(int'(sbox[a ^ b]));
        @(posedge clk); #1;
        if (exp_q.size() >= 3) check_entry(exp_q.pop_front());
    endtask

    // Hold reset for n edges, checking for zero outputs, then release it.
    // The first two edges after release must still show zeros.
    task automatic apply_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            n_vec++;
            assert ({A_out, B_out} === 8'h00) else begin
                n_bad++;
                $error("FAIL %s: reset shares observed %h/%h expected 0/0", tag, A_out, B_out);
            end
        end
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(EXP_ZERO);
        exp_q.push_back(EXP_ZERO);
    endtask

    // Directed sequence of scenarios.
    initial begin
        logic [3:0] ra;
        logic [3:0] first_a;
        bit         varied;
        sbox = '{4'h6, 4'hB, 4'h5, 4'h4, 4'h2, 4'hE, 4'h7, 4'hA,
                 4'h9, 4'hD, 4'hF, 4'hC, 4'h3, 4'h1, 4'h0, 4'h8};

        tag = "reset";
        apply_reset(2);

        // All-zero input with fixed randomness: 0,0 then 6 from the third edge.
        tag = "held_zero";
        Z0 = 2'h2;  Z1 = 2'h0;  Z2 = 2'h1;
        Az0 = 2'h1; Az1 = 2'h3; Az2 = 2'h0;
        Bz0 = 2'h3; Bz1 = 2'h1; Bz2 = 2'h2;
        for (int i = 0; i < 6; i++) step(4'h0, 4'h0, 1'b1);

        tag = "exhaustive";
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                step(4'(a), 4'(b), 1'b0);

        tag = "split";
        step(4'h5, 4'h0, 1'b0);
        step(4'h0, 4'h5, 1'b0);
        step(4'hF, 4'hA, 1'b0);

        tag = "stream";
        for (int x = 0; x < 16; x++) begin
            ra = 4'($urandom);
            step(ra, ra ^ 4'(x), 1'b0);
        end

        // Reset mid-stream: in-flight values are discarded.
        tag = "midreset";
        for (int i = 0; i < 4; i++) step(4'($urandom), 4'($urandom), 1'b0);
        apply_reset(1);
        tag = "after_reset";
        for (int x = 0; x < 8; x++) begin
            ra = 4'($urandom);
            step(ra, ra ^ 4'(x * 3), 1'b0);
        end

        // Fixed X = 9 with a fixed split; only the randomness changes.
        tag = "rand_only";
        varied  = 1'b0;
        first_a = 4'h0;
        for (int i = 0; i < 18; i++) begin
            step(4'h3, 4'hA, 1'b0);
            if (i == 2) first_a = A_out;
            else if (i > 2 && A_out !== first_a) varied = 1'b1;
        end
        n_vec++;
        assert (varied === 1'b1) else begin
            n_bad++;
            $error("FAIL share_variation: observed %b expected 1", varied);
        end

        tag = "tail";
        for (int i = 0; i < 3; i++) step(4'($urandom), 4'($urandom), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
